hack_ram_arbiter: RTL



---
 rtl/hack_mem_pkg.sv | 35 +++
 rtl/hack_ram_clear.sv | 56 +++++
 rtl/hack_ram_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hack_mem_pkg.sv
// ---------------------------------------------------------------------------
// hack_mem_pkg
// Shared definitions for the Hack data-RAM front end.
//   - Default address/data widths and the full RAM depth.
//   - Arbiter state enum (CLEAR while the RAM is being zeroed, RUN afterwards).
//   - Width of the video starvation counter and its saturating increment.
// ---------------------------------------------------------------------------
package hack_mem_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 16;
    localparam int RAM_DEPTH  = 16384;

    // STARVE_LIMIT is limited to 1..15, so four bits always hold the count.
    localparam int STARVE_W   = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_e;

    // Increment that sticks at lim. Sticking exactly at the limit (rather than
    // at the counter's all-ones value) keeps the equality test in the grant
    // logic true for as long as video keeps waiting.
    function automatic logic [STARVE_W-1:0] sat_inc(
        input logic [STARVE_W-1:0] value,
        input logic [STARVE_W-1:0] lim
    );
        if (value >= lim) begin
            return lim;
        end
        return value + 1'b1;
    endfunction

endpackage

// File: rtl/hack_ram_clear.sv
// ---------------------------------------------------------------------------
// hack_ram_clear
// Post-reset RAM scrubber: walks addresses 0..DEPTH-1, one per cycle, asking
// for a zero write at each, then raises done and stays idle until the next
// reset.
//
// Ports
//   clock   in   rising-edge clock
//   reset   in   synchronous, active-high; restarts the walk at address 0
//   o_addr  out  address to clear this cycle
//   o_load  out  1 while the walk is still in progress
//   o_last  out  1 in the cycle that writes address DEPTH-1
//   o_done  out  registered; 1 once every word has been written
// ---------------------------------------------------------------------------
module hack_ram_clear
    import hack_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = RAM_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_load,
    output logic              o_last,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] r_cnt;
    logic              r_done;
    logic              w_last;

    assign w_last = !r_done && (r_cnt == LAST_ADDR);

    // The counter parks on the last address once done; nothing reads it then.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!r_done) begin
            if (w_last) begin
                r_done <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_addr = r_cnt;
    assign o_load = !r_done;
    assign o_last = w_last;
    assign o_done = r_done;

endmodule

// File: rtl/hack_ram_arbiter.sv
// ---------------------------------------------------------------------------
// hack_ram_arbiter
// Owns the single port of the Hack data RAM. After reset it zeroes DEPTH
// words (via hack_ram_clear), then arbitrates each cycle between the CPU
// data port (read/write, fixed priority) and the video scan-out reader
// (read-only). If video has been refused STARVE_LIMIT cycles in a row while
// still requesting, it wins the next cycle.
//
// Ports
//   clock, reset                 clock and synchronous active-high reset
//   cpu_req/we/addr/wdata   in   CPU request, held until cpu_gnt
//   cpu_gnt                 out  combinational grant; access happens at this edge
//   cpu_rdata/cpu_rvalid    out  registered read data, valid pulse one cycle later
//   vid_req/vid_addr        in   video read request
//   vid_gnt                 out  combinational grant
//   vid_rdata/vid_rvalid    out  registered read data, valid pulse one cycle later
//   init_done               out  1 once the clear walk has finished
//   ram_load/addr/in_data   out  to hack_ram
//   ram_out_data            in   from hack_ram (combinational read)
// ---------------------------------------------------------------------------
module hack_ram_arbiter
    import hack_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int DEPTH        = RAM_DEPTH,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,

    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,

    output logic              init_done,

    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in_data,
    input  logic [DATA_W-1:0] ram_out_data
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    arb_state_e          r_state;
    logic [STARVE_W-1:0] r_vid_wait;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_vid_rdata;
    logic                r_cpu_rvalid;
    logic                r_vid_rvalid;

    logic [ADDR_W-1:0]   w_clr_addr;
    logic                w_clr_load;
    logic                w_clr_last;
    logic                w_clr_done;

    logic                w_run;
    logic                w_vid_starved;
    logic                w_cpu_gnt;
    logic                w_vid_gnt;
    logic                w_cpu_read;

    // -----------------------------------------------------------------------
    // Clear walk
    // -----------------------------------------------------------------------
    hack_ram_clear #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear (
        .clock  (clock),
        .reset  (reset),
        .o_addr (w_clr_addr),
        .o_load (w_clr_load),
        .o_last (w_clr_last),
        .o_done (w_clr_done)
    );

    // -----------------------------------------------------------------------
    // Grant logic. Reset is folded in here so that no grant (and therefore
    // no RAM write) can slip through while reset is held in RUN.
    // -----------------------------------------------------------------------
    assign w_run         = (r_state == RUN) && !reset;
    assign w_vid_starved = (r_vid_wait == LIMIT) && vid_req;
    assign w_cpu_gnt     = w_run && cpu_req && !w_vid_starved;
    assign w_vid_gnt     = w_run && vid_req && !w_cpu_gnt;
    assign w_cpu_read    = w_cpu_gnt && !cpu_we;

    // -----------------------------------------------------------------------
    // State, starvation counter and read-return registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= CLEAR;
            r_vid_wait   <= '0;
            r_cpu_rdata  <= '0;
            r_vid_rdata  <= '0;
            r_cpu_rvalid <= 1'b0;
            r_vid_rvalid <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (w_clr_last) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= CLEAR;
                end
            endcase

            // Counts only while video is actually asking and being refused,
            // including during the clear walk.
            if (!vid_req || w_vid_gnt) begin
                r_vid_wait <= '0;
            end else begin
                r_vid_wait <= sat_inc(r_vid_wait, LIMIT);
            end

            // rdata holds its last value between read grants to its port.
            r_cpu_rvalid <= w_cpu_read;
            if (w_cpu_read) begin
                r_cpu_rdata <= ram_out_data;
            end

            r_vid_rvalid <= w_vid_gnt;
            if (w_vid_gnt) begin
                r_vid_rdata <= ram_out_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // RAM port mux: clear walk, then CPU, then video, else idle at address 0.
    // -----------------------------------------------------------------------
    always_comb begin
        ram_load    = 1'b0;
        ram_addr    = '0;
        ram_in_data = '0;
        if (r_state == CLEAR) begin
            ram_load = w_clr_load && !reset;
            ram_addr = w_clr_addr;
        end else if (w_cpu_gnt) begin
            ram_load    = cpu_we;
            ram_addr    = cpu_addr;
            ram_in_data = cpu_wdata;
        end else if (w_vid_gnt) begin
            ram_addr = vid_addr;
        end
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign vid_gnt    = w_vid_gnt;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_rvalid = r_cpu_rvalid;
    assign vid_rdata  = r_vid_rdata;
    assign vid_rvalid = r_vid_rvalid;
    assign init_done  = w_clr_done;

endmodule
